logic16_arbiter: RTL and testbench

//   Shares one 16-bit bitwise logic datapath (And/Or/Xor/Not per bit) between two requesters.

---
 rtl/hack_pkg.sv | 20 ++
 rtl/logic16_unit.sv | 51 +++++
 rtl/logic16_arbiter.sv | 103 ++++++++++
 tb/tb_logic16_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the 16-bit logic datapath and its arbiter.
//   op_e    : bitwise operation selector (AND/OR/XOR/NOT a)
//   state_e : arbiter FSM state encoding
//   DEF_WIDTH : default operand/result width
package hack_pkg;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;
endpackage

// File: rtl/logic16_unit.sv
// Combinational bitwise logic unit: WIDTH independent 1-bit gate slices.
//   op : operation select (op_e)
//   a  : operand a
//   b  : operand b (ignored for OP_NOT)
//   y  : result; bit i depends only on a[i], b[i]
module logic1_gate
  import hack_pkg::*;
(
  input  op_e  op,
  input  logic a,
  input  logic b,
  output logic y
);
  logic g_and, g_or, g_xor, g_not;

  assign g_and = a & b;
  assign g_or  = a | b;
  assign g_xor = a ^ b;
  assign g_not = ~a;

  always_comb begin
    y = g_and;
    case (op)
      OP_AND:  y = g_and;
      OP_OR:   y = g_or;
      OP_XOR:  y = g_xor;
      OP_NOT:  y = g_not;
      default: y = g_and;
    endcase
  end
endmodule

module logic16_unit
  import hack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic1_gate u_gate (
      .op (op),
      .a  (a[i]),
      .b  (b[i]),
      .y  (y[i])
    );
  end
endmodule

// File: rtl/logic16_arbiter.sv
// Two-port round-robin arbiter in front of the shared bitwise logic unit.
//   clk, reset : clock, synchronous active-high reset
//   req_*      : per-port valid/ready request (op, a, b)
//   rsp_*      : per-port valid/ready response; rsp_data shared by both ports
//   busy       : high whenever a transaction is in flight
// One transaction at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold result).
module logic16_arbiter
  import hack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][1:0]       req_op,
  input  logic [NREQ-1:0][WIDTH-1:0] req_a,
  input  logic [NREQ-1:0][WIDTH-1:0] req_b,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       busy
);
  if (NREQ != 2) begin : g_nreq_chk
    $error("logic16_arbiter supports exactly two requesters");
  end

  state_e           state;
  logic             rr_last;   // port granted most recently
  logic             g_r;       // port owning the in-flight transaction
  op_e              op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] unit_y;
  logic             win;
  logic [1:0]       grant;

  // Winner selection: contention goes to the port that did not win last.
  // Grant is suppressed while reset is high so no request is consumed then.
  always_comb begin
    win   = 1'b0;
    grant = 2'b00;
    if (state == ST_IDLE && !reset && req_valid != 2'b00) begin
      win   = (req_valid == 2'b11) ? ~rr_last : req_valid[1];
      grant = 2'b01 << win;
    end
  end

  assign req_ready = grant;

  logic16_unit #(.WIDTH(WIDTH)) u_unit (
    .op (op_r),
    .a  (a_r),
    .b  (b_r),
    .y  (unit_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_last   <= 1'b1;
      g_r       <= 1'b0;
      op_r      <= OP_AND;
      a_r       <= '0;
      b_r       <= '0;
      rsp_data  <= '0;
      rsp_valid <= 2'b00;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            op_r  <= op_e'(req_op[win]);
            a_r   <= req_a[win];
            b_r   <= req_b[win];
            g_r   <= win;
            busy  <= 1'b1;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= unit_y;
          rsp_valid <= 2'b01 << g_r;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          // rsp_ready on the other port has no effect.
          if (rsp_ready[g_r]) begin
            rr_last   <= g_r;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed bench for logic16_arbiter with a transaction-level reference model
// checked on every falling edge, plus literal expectations per scenario.
module tb_logic16_arbiter;
  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0][1:0]   req_op;
  logic [1:0][15:0]  req_a, req_b;
  logic [15:0]       rsp_data;
  logic              busy;

  logic16_arbiter #(.WIDTH(16), .NREQ(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                         input logic [15:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // Transaction-level model: is a transaction in flight, how old is it,
  // who owns it, and what the result register should hold.
  bit          m_busy = 0;
  int          m_age  = 0;
  int          m_port = 0;
  int          m_last = 1;
  logic [15:0] m_res  = '0;
  logic [15:0] m_data = '0;

  // Observed handshakes, for scenario-level literal checks.
  int          g_port[$], g_cyc[$], r_port[$], r_cyc[$];
  logic [15:0] r_data[$];

  always @(negedge clk) begin : cmp
    logic [1:0] er, ev;
    int w;
    if (chk_en) begin
      er = 2'b00;
      w  = 0;
      if (!m_busy && !reset && req_valid != 2'b00) begin
        w  = (req_valid == 2'b11) ? ((m_last == 1) ? 0 : 1) : (req_valid[1] ? 1 : 0);
        er = 2'b01 << w;
      end
      ev = (m_busy && m_age == 2) ? (2'b01 << m_port) : 2'b00;
      chk("req_ready", {30'd0, req_ready}, {30'd0, er});
      chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, ev});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("rsp_data", {16'd0, rsp_data}, {16'd0, m_data});

      if ((req_valid & req_ready) != 2'b00) begin
        g_port.push_back(req_ready[1] ? 1 : 0);
        g_cyc.push_back(cyc);
      end
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        r_port.push_back(rsp_valid[1] ? 1 : 0);
        r_data.push_back(rsp_data);
        r_cyc.push_back(cyc);
      end

      if (reset) begin
        m_busy = 0; m_last = 1; m_data = '0; m_age = 0;
      end else if (!m_busy) begin
        if (er != 2'b00) begin
          m_busy = 1; m_age = 1; m_port = w;
          m_res  = ref_op(req_op[w], req_a[w], req_b[w]);
        end
      end else if (m_age == 1) begin
        m_data = m_res; m_age = 2;
      end else if (rsp_ready[m_port]) begin
        m_last = m_port; m_busy = 0; m_age = 0;
      end
    end
  end

  typedef struct { logic [1:0] op; logic [15:0] a; logic [15:0] b; } rq_t;
  rq_t q0[$], q1[$];
  rq_t inj_item;
  bit  inj_pending = 0;
  int  inj_at = 0;
  int  stall = 0;

  function automatic rq_t mk(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    rq_t r; r.op = op; r.a = a; r.b = b; return r;
  endfunction

  task automatic clear_logs();
    g_port.delete(); g_cyc.delete(); r_port.delete(); r_data.delete(); r_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Drives both request queues until drained and the DUT is idle again.
  task automatic run(input int maxc);
    int c;
    logic [1:0] pop;
    c = 0;
    forever begin
      if (inj_pending && c == inj_at) begin q0.push_back(inj_item); inj_pending = 0; end
      rsp_ready = (stall > 0) ? 2'b00 : 2'b11;
      req_valid[0] = (q0.size() != 0);
      if (q0.size() != 0) begin req_op[0] = q0[0].op; req_a[0] = q0[0].a; req_b[0] = q0[0].b; end
      req_valid[1] = (q1.size() != 0);
      if (q1.size() != 0) begin req_op[1] = q1[0].op; req_a[1] = q1[0].a; req_b[1] = q1[0].b; end
      @(negedge clk);
      pop = req_valid & req_ready;
      if (rsp_valid != 2'b00 && stall > 0) stall--;
      @(posedge clk); #1;
      if (pop[0]) begin q0.delete(0); req_valid[0] = 1'b0; end
      if (pop[1]) begin q1.delete(0); req_valid[1] = 1'b0; end
      c++;
      if (q0.size() == 0 && q1.size() == 0 && !inj_pending && !busy) break;
      if (c >= maxc) begin
        asserts++; fails++;
        $display("FAIL run_timeout: still busy after %0d cycles", c);
        q0.delete(); q1.delete(); inj_pending = 0; stall = 0; req_valid = 2'b00;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset held two cycles with both requests valid
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
    req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 2'b00;

    // 2: single OR on port 0
    clear_logs();
    q0.push_back(mk(2'b01, 16'h00F0, 16'h0F0F));
    run(30);
    chk("t2_ngrant", g_port.size(), 1);
    chk("t2_nrsp", r_port.size(), 1);
    if (r_port.size() == 1 && g_cyc.size() == 1) begin
      chk("t2_data", {16'd0, r_data[0]}, 32'h0FFF);
      chk("t2_port", r_port[0], 0);
      chk("t2_latency", r_cyc[0] - g_cyc[0], 2);
    end

    // 3: contention after reset, grants alternate starting at port 0
    do_reset();
    clear_logs();
    q0.push_back(mk(2'b00, 16'hFFFF, 16'h1234));
    q0.push_back(mk(2'b01, 16'h0001, 16'h0100));
    q1.push_back(mk(2'b10, 16'hAAAA, 16'hFFFF));
    q1.push_back(mk(2'b00, 16'hF0F0, 16'h3C3C));
    run(60);
    chk("t3_ngrant", g_port.size(), 4);
    chk("t3_nrsp", r_data.size(), 4);
    if (g_port.size() == 4 && r_data.size() == 4) begin
      chk("t3_g0", g_port[0], 0); chk("t3_g1", g_port[1], 1);
      chk("t3_g2", g_port[2], 0); chk("t3_g3", g_port[3], 1);
      chk("t3_d0", {16'd0, r_data[0]}, 32'h1234);
      chk("t3_d1", {16'd0, r_data[1]}, 32'h5555);
      chk("t3_d2", {16'd0, r_data[2]}, 32'h0101);
      chk("t3_d3", {16'd0, r_data[3]}, 32'h3030);
    end

    // 4: port 1 NOT under 5-cycle backpressure, port 0 arrives mid-stall
    clear_logs();
    stall = 5;
    inj_item = mk(2'b01, 16'h0F00, 16'h00F0);
    inj_at = 2; inj_pending = 1;
    q1.push_back(mk(2'b11, 16'h00FF, 16'h1234));
    run(60);
    chk("t4_ngrant", g_port.size(), 2);
    chk("t4_nrsp", r_data.size(), 2);
    if (g_port.size() == 2 && r_data.size() == 2) begin
      chk("t4_g0", g_port[0], 1); chk("t4_g1", g_port[1], 0);
      chk("t4_d0", {16'd0, r_data[0]}, 32'hFF00);
      chk("t4_d1", {16'd0, r_data[1]}, 32'h0FF0);
      chk("t4_stall_len", r_cyc[0] - g_cyc[0], 7);
    end

    // 5: reset while in EXEC discards the transaction
    clear_logs();
    rsp_ready = 2'b11;
    req_valid = 2'b01; req_op[0] = 2'b00; req_a[0] = 16'hFFFF; req_b[0] = 16'h00FF;
    @(negedge clk);
    chk("t5_accept", {30'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 2'b00; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t5_no_rsp", r_data.size(), 0);
    clear_logs();
    q0.push_back(mk(2'b10, 16'hFF00, 16'h0FF0));
    q1.push_back(mk(2'b11, 16'h1234, 16'h0000));
    run(40);
    chk("t5_ngrant", g_port.size(), 2);
    if (g_port.size() == 2 && r_data.size() == 2) begin
      chk("t5_g0", g_port[0], 0); chk("t5_g1", g_port[1], 1);
      chk("t5_d0", {16'd0, r_data[0]}, 32'hF0F0);
      chk("t5_d1", {16'd0, r_data[1]}, 32'hEDCB);
    end

    // 6: lone port 1, three back-to-back requests
    clear_logs();
    q1.push_back(mk(2'b00, 16'h00FF, 16'h0F0F));
    q1.push_back(mk(2'b01, 16'h1000, 16'h0001));
    q1.push_back(mk(2'b10, 16'hFFFF, 16'h0001));
    run(40);
    chk("t6_ngrant", g_port.size(), 3);
    if (g_port.size() == 3 && r_data.size() == 3) begin
      chk("t6_g0", g_port[0], 1); chk("t6_g1", g_port[1], 1); chk("t6_g2", g_port[2], 1);
      chk("t6_gap1", g_cyc[1] - g_cyc[0], 3);
      chk("t6_gap2", g_cyc[2] - g_cyc[1], 3);
      chk("t6_d0", {16'd0, r_data[0]}, 32'h000F);
      chk("t6_d1", {16'd0, r_data[1]}, 32'h1001);
      chk("t6_d2", {16'd0, r_data[2]}, 32'hFFFE);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
